// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the SEQ Y86-64 datapath: one-hot-style stage enables,
// data-memory handshake with timeout, and processor status. Optional counters: SEQ_PERF_CNT_EN.
module seq_stage_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop_req,
    input  logic [3:0] icode,
    input  logic       instr_valid,
    input  logic       imem_error,
    input  logic       dmem_ack,
    input  logic       dmem_error,
    output logic       fetch_en,
    output logic       decode_en,
    output logic       exec_en,
    output logic       cc_en,
    output logic       mem_req,
    output logic       mem_write,
    output logic       wb_en,
    output logic       pc_en,
    output logic       retire,
    output logic [2:0] stat,
    output logic       busy,
    output logic       halted,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count,
`endif
    output logic [2:0] state
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEMORY  = 3'd4,
        S_WB      = 3'd5,
        S_PCUPD   = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    stat_q, stat_d;
    logic [3:0]    icode_q, icode_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            stat_q  <= STAT_AOK;
            icode_q <= 4'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            icode_q <= icode_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        icode_d = icode_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_error) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else if (!instr_valid || icode > 4'hB) begin
                    state_d = S_HALT;
                    stat_d  = STAT_INS;
                end else if (icode == 4'h0) begin
                    state_d = S_HALT;
                    stat_d  = STAT_HLT;
                end else begin
                    icode_d = icode;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
                    state_d = S_MEMORY;
                    cnt_d   = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEMORY: begin
                // An ack on the timeout boundary cycle still completes the access.
                if (dmem_ack) begin
                    if (dmem_error) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB:    state_d = S_PCUPD;
            S_PCUPD: state_d = stop_req ? S_IDLE : S_FETCH;
            default: state_d = S_HALT;
        endcase
    end

    assign fetch_en  = (state_q == S_FETCH);
    assign decode_en = (state_q == S_DECODE);
    assign exec_en   = (state_q == S_EXECUTE);
    assign cc_en     = (state_q == S_EXECUTE) && (icode_q == 4'h6);
    assign mem_req   = (state_q == S_MEMORY);
    assign mem_write = (state_q == S_MEMORY) && (icode_q inside {4'h4, 4'h8, 4'hA});
    assign wb_en     = (state_q == S_WB) &&
                       (icode_q inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB});
    assign pc_en     = (state_q == S_PCUPD);
    assign retire    = (state_q == S_PCUPD);
    assign stat      = stat_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted    = (state_q == S_HALT);
    assign state     = state_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cyc_cnt_q, ins_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_q <= '0;
            ins_cnt_q <= '0;
        end else begin
            if (busy)   cyc_cnt_q <= cyc_cnt_q + 32'd1;
            if (retire) ins_cnt_q <= ins_cnt_q + 32'd1;
        end
    end

    assign cycle_count = cyc_cnt_q;
    assign instr_count = ins_cnt_q;
`endif

endmodule
